// File: rtl/fifo_wr_arbiter_if.sv
// Producer handshakes and FIFO write port shared by fifo_wr_arbiter.
// master: producers/FIFO environment; slave: the arbiter.
interface fifo_wr_arbiter_if #(
    parameter int unsigned DW = 8
);
    logic          req0_valid;
    logic [DW-1:0] req0_data;
    logic          req0_ready;
    logic          req1_valid;
    logic [DW-1:0] req1_data;
    logic          req1_ready;
    logic          fifo_full;
    logic          fifo_wr_en;
    logic [DW-1:0] fifo_data_in;
    logic [1:0]    grant;

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, fifo_full,
        input  req0_ready, req1_ready, fifo_wr_en, fifo_data_in, grant
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, fifo_full,
        output req0_ready, req1_ready, fifo_wr_en, fifo_data_in, grant
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port between two producers.
// Define FIFO_ARB_STATS_EN to add per-port 16-bit transfer counters wcnt0/wcnt1.
module fifo_wr_arbiter #(
    parameter int unsigned DW        = 8,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    fifo_wr_arbiter_if.slave   bus
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [15:0]        wcnt0,
    output logic [15:0]        wcnt1
`endif
);

    localparam int unsigned CW = $clog2(BURST_LEN + 1);
    localparam logic [CW-1:0] BL = CW'(BURST_LEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic          last, last_nxt;
    logic [CW-1:0] bcnt, bcnt_nxt;

    logic          sel;
    logic          own_v;
    logic          oth_v;
    logic [DW-1:0] own_d;
    logic [DW-1:0] data_c;
    logic          xfer_c;
    logic          burst_done;
    logic [CW-1:0] bcnt_inc;

    // State, last-served port and burst count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            last  <= 1'b1;
            bcnt  <= '0;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
            bcnt  <= bcnt_nxt;
        end
    end

    // Owner-relative view of the two ports while granted
    assign sel      = (state == GNT1);
    assign own_v    = sel ? bus.req1_valid : bus.req0_valid;
    assign oth_v    = sel ? bus.req0_valid : bus.req1_valid;
    assign own_d    = sel ? bus.req1_data  : bus.req0_data;
    assign bcnt_inc = bcnt + CW'(1);

    // Next-state and combinational port outputs
    always_comb begin
        state_nxt      = state;
        last_nxt       = last;
        bcnt_nxt       = bcnt;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.grant      = 2'b00;
        data_c         = '0;
        xfer_c         = 1'b0;
        burst_done     = 1'b0;

        case (state)
            IDLE: begin
                // Both valid: serve the port that was not served last
                if (bus.req0_valid && (!bus.req1_valid || last)) begin
                    state_nxt = GNT0;
                    last_nxt  = 1'b0;
                    bcnt_nxt  = '0;
                end else if (bus.req1_valid) begin
                    state_nxt = GNT1;
                    last_nxt  = 1'b1;
                    bcnt_nxt  = '0;
                end
            end
            GNT0, GNT1: begin
                bus.req0_ready = !sel && !bus.fifo_full;
                bus.req1_ready =  sel && !bus.fifo_full;
                bus.grant      = sel ? 2'b10 : 2'b01;
                data_c         = own_d;
                xfer_c         = own_v && !bus.fifo_full;
                burst_done     = xfer_c && (bcnt_inc == BL);

                // A full FIFO with valid held keeps everything frozen
                if (!own_v || burst_done) begin
                    bcnt_nxt = '0;
                    if (oth_v) begin
                        state_nxt = sel ? GNT0 : GNT1;
                        last_nxt  = !sel;
                    end else if (!own_v) begin
                        state_nxt = IDLE;
                    end
                end else if (xfer_c) begin
                    bcnt_nxt = bcnt_inc;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.fifo_wr_en   = xfer_c;
    assign bus.fifo_data_in = data_c;

`ifdef FIFO_ARB_STATS_EN
    // Per-port accepted-word counters, wrapping modulo 2^16
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wcnt0 <= '0;
            wcnt1 <= '0;
        end else begin
            wcnt0 <= wcnt0 + 16'(bus.req0_valid && bus.req0_ready);
            wcnt1 <= wcnt1 + 16'(bus.req1_valid && bus.req1_ready);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (BURST_LEN=4, DW=8).
module tb_fifo_wr_arbiter;

    localparam int unsigned DW = 8;
    localparam int unsigned BL = 4;

    logic       clk;
    logic       reset_n;
    int         checks = 0;
    int         errors = 0;
    int         cnt0;
    int         cnt1;
    logic [7:0] base0;
    logic [7:0] base1;
    logic [1:0] exp_g;
    logic [7:0] exp_d;
    int         k;
    logic [7:0] exp_single [6] = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};

    fifo_wr_arbiter_if #(.DW(DW)) bus ();

`ifdef FIFO_ARB_STATS_EN
    logic [15:0] wcnt0;
    logic [15:0] wcnt1;
`endif

    fifo_wr_arbiter #(
        .DW        (DW),
        .BURST_LEN (BL)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef FIFO_ARB_STATS_EN
        ,
        .wcnt0   (wcnt0),
        .wcnt1   (wcnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_data();
        bus.req0_data = base0 + 8'(cnt0);
        bus.req1_data = base1 + 8'(cnt1);
    endtask

    // Advance one clock; producers step to their next word on a handshake
    task automatic tick();
        logic a0, a1;
        a0 = bus.req0_valid && bus.req0_ready;
        a1 = bus.req1_valid && bus.req1_ready;
        @(posedge clk);
        #1;
        if (a0) cnt0++;
        if (a1) cnt1++;
        drive_data();
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_grant"}, 32'(bus.grant), 0);
        chk({tag, "_rdy0"},  32'(bus.req0_ready), 0);
        chk({tag, "_rdy1"},  32'(bus.req1_ready), 0);
        chk({tag, "_wr_en"}, 32'(bus.fifo_wr_en), 0);
        chk({tag, "_data"},  32'(bus.fifo_data_in), 0);
`ifdef FIFO_ARB_STATS_EN
        chk({tag, "_wcnt0"}, 32'(wcnt0), 0);
        chk({tag, "_wcnt1"}, 32'(wcnt1), 0);
`endif
    endtask

    initial begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.fifo_full  = 1'b0;
        base0 = 8'h11;
        base1 = 8'h00;
        cnt0  = 0;
        cnt1  = 0;
        drive_data();
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        #1 check_zero("rst0");
        tick();
        reset_n = 1'b1;

        // Single producer streams past the burst limit without losing the grant
        bus.req0_valid = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            chk("single_grant", 32'(bus.grant), 1);
            chk("single_wr_en", 32'(bus.fifo_wr_en), 1);
            chk("single_data",  32'(bus.fifo_data_in), 32'(exp_single[i]));
            tick();
        end
        bus.req0_valid = 1'b0;
        #1;
        chk("single_drop_wr_en", 32'(bus.fifo_wr_en), 0);
        tick();
        chk("single_idle_grant", 32'(bus.grant), 0);

        // Contention: both valid from reset, bursts of 4 alternate with no gap
        reset_n = 1'b0;
        #1;
        base0 = 8'hA0;
        base1 = 8'hB0;
        cnt0  = 0;
        cnt1  = 0;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        drive_data();
        #1 check_zero("rst1");
        #1 reset_n = 1'b1;
        tick();
        for (int i = 0; i < 24; i++) begin
            exp_g = (((i / 4) % 2) == 0) ? 2'b01 : 2'b10;
            k     = (i / 8) * 4 + (i % 4);
            exp_d = (exp_g == 2'b01) ? (8'hA0 + 8'(k)) : (8'hB0 + 8'(k));
            chk("cont_grant", 32'(bus.grant), 32'(exp_g));
            chk("cont_wr_en", 32'(bus.fifo_wr_en), 1);
            chk("cont_data",  32'(bus.fifo_data_in), 32'(exp_d));
            tick();
        end
`ifdef FIFO_ARB_STATS_EN
        chk("stats_wcnt0", 32'(wcnt0), 12);
        chk("stats_wcnt1", 32'(wcnt1), 12);
`endif

        // Full stall mid-burst freezes the burst count and the grant
        reset_n = 1'b0;
        #1;
        base0 = 8'h30;
        base1 = 8'h40;
        cnt0  = 0;
        cnt1  = 0;
        drive_data();
        #1 reset_n = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            chk("stall_pre_grant", 32'(bus.grant), 1);
            chk("stall_pre_data",  32'(bus.fifo_data_in), 32'h30 + 32'(i));
            tick();
        end
        bus.fifo_full = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("stall_wr_en", 32'(bus.fifo_wr_en), 0);
            chk("stall_rdy0",  32'(bus.req0_ready), 0);
            chk("stall_rdy1",  32'(bus.req1_ready), 0);
            chk("stall_grant", 32'(bus.grant), 1);
            tick();
        end
        bus.fifo_full = 1'b0;
        #1;
        for (int i = 2; i < 4; i++) begin
            chk("stall_post_grant", 32'(bus.grant), 1);
            chk("stall_post_wr_en", 32'(bus.fifo_wr_en), 1);
            chk("stall_post_data",  32'(bus.fifo_data_in), 32'h30 + 32'(i));
            tick();
        end
        chk("rot_grant", 32'(bus.grant), 2);
        chk("rot_data",  32'(bus.fifo_data_in), 32'h40);

        // Early release: port 1 drops valid after two words
        tick();
        chk("early_w2_data", 32'(bus.fifo_data_in), 32'h41);
        tick();
        bus.req1_valid = 1'b0;
        #1;
        chk("early_drop_wr_en", 32'(bus.fifo_wr_en), 0);
        chk("early_drop_grant", 32'(bus.grant), 2);
        tick();
        chk("early_grant", 32'(bus.grant), 1);
        chk("early_data",  32'(bus.fifo_data_in), 32'h34);
        chk("early_wr_en", 32'(bus.fifo_wr_en), 1);

        // Asynchronous reset between edges while port 0 is bursting
        bus.req1_valid = 1'b1;
        tick();
        #2 reset_n = 1'b0;
        #1 check_zero("rst_mid");
        #1 reset_n = 1'b1;
        tick();
        chk("post_rst_grant", 32'(bus.grant), 1);
        chk("post_rst_data",  32'(bus.fifo_data_in), 32'h35);
        chk("post_rst_wr_en", 32'(bus.fifo_wr_en), 1);
        chk("post_rst_rdy1",  32'(bus.req1_ready), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
